// File: rtl/axis_dac_sample_pacer.sv
// Paces buffered 32-bit DMA words out as one 14-bit offset-binary DAC sample per rate tick.
// Optional build macro PACER_UNDERRUN_FILL_EN: a starved tick emits midscale (0x2000) instead of nothing.
module axis_dac_sample_pacer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 16,
  parameter int FIFO_AW                = 4
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  enable,
  input  logic [15:0]                           rate_div,
  input  logic [FIFO_AW:0]                      prime_level,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic                                  s00_axis_tvalid,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic [15:0]                           underrun_count,
  output logic [FIFO_AW:0]                      fifo_level,
  output logic [1:0]                            state
);

  // Both AXIS ports use valid/ready: a transfer happens on a rising clock edge where
  // tvalid and tready are both high; once tvalid is raised, data/last hold until that edge.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int              WORD_W  = C_S00_AXIS_TDATA_WIDTH + 1;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [13:0]      MIDSCALE = 14'h2000;

  state_t cur_state, nxt_state;

  logic [WORD_W-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level, last_cnt;
  logic [FIFO_AW:0]   prime_q;
  logic [15:0]        rate_q, pace_cnt;
  logic               half_sel, pending;
  logic               out_valid, out_last;
  logic [13:0]        out_sample;

  logic               full, empty, accepting, push, pop;
  logic               out_hs, last_hs, out_free, tick, run_ok, serve, issue, starved;
  logic               prime_hit, flush;
  logic [WORD_W-1:0]  rd_word;
  logic [15:0]        sample_in;
  logic [13:0]        conv;

  logic unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;

  // ---------------- combinational datapath / control ----------------
  assign full      = (level == DEPTH_L);
  assign empty     = (level == '0);
  assign accepting = (cur_state == ST_PRIME) || (cur_state == ST_RUN);
  assign s00_axis_tready = !full && accepting;
  assign push      = s00_axis_tvalid && s00_axis_tready;

  assign out_hs    = out_valid && m00_axis_tready;
  assign last_hs   = out_hs && out_last;
  assign out_free  = !out_valid || m00_axis_tready;

  assign tick      = (cur_state == ST_RUN) && (pace_cnt == 16'd0);
  // An outgoing tlast handshake ends the burst, so nothing new is issued that cycle.
  assign run_ok    = (cur_state == ST_RUN) && enable && !last_hs;
  assign serve     = run_ok && (tick || pending) && out_free;
  assign issue     = serve && !empty;
  assign starved   = serve && empty;
  assign pop       = issue && half_sel;

  assign rd_word   = mem[rd_ptr];
  assign sample_in = half_sel ? rd_word[31:16] : rd_word[15:0];
  assign conv      = {~sample_in[15], sample_in[14:2]};

  assign prime_hit = (level >= prime_q) || (last_cnt != '0);
  assign flush     = (cur_state == ST_STOP) && out_free;

  // ---------------- FSM ----------------
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) cur_state <= ST_IDLE;
    else                   cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:  if (enable) nxt_state = ST_PRIME;
      ST_PRIME: begin
        if (!enable)        nxt_state = ST_STOP;
        else if (prime_hit) nxt_state = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)      nxt_state = ST_STOP;
        else if (last_hs) nxt_state = ST_PRIME;
      end
      ST_STOP:  if (out_free) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  assign state = cur_state;

  // ---------------- configuration latch and pacing ----------------
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      rate_q  <= 16'd1;
      prime_q <= LVL_ONE;
    end else if (cur_state == ST_IDLE && enable) begin
      rate_q <= (rate_div == 16'd0) ? 16'd1 : rate_div;
      if (prime_level == '0)          prime_q <= LVL_ONE;
      else if (prime_level > DEPTH_L) prime_q <= DEPTH_L;
      else                            prime_q <= prime_level;
    end
  end

  // Counter only advances while staying in RUN, so every RUN entry starts with a tick.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      pace_cnt <= 16'd0;
    end else if (cur_state == ST_RUN && nxt_state == ST_RUN) begin
      pace_cnt <= (pace_cnt >= rate_q - 16'd1) ? 16'd0 : pace_cnt + 16'd1;
    end else begin
      pace_cnt <= 16'd0;
    end
  end

  // At most one stalled tick is remembered; later stalled ticks are dropped.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      pending <= 1'b0;
    end else if (cur_state != ST_RUN || last_hs || serve) begin
      pending <= 1'b0;
    end else if (tick && !out_free) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      underrun_count <= 16'd0;
    end else if (starved && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

  // ---------------- word FIFO ----------------
  always_ff @(posedge s00_axis_aclk) begin
    if (push) mem[wr_ptr] <= {s00_axis_tlast, s00_axis_tdata};
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_cnt <= '0;
      half_sel <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_cnt <= '0;
      half_sel <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      case ({push && s00_axis_tlast, pop && rd_word[WORD_W-1]})
        2'b10:   last_cnt <= last_cnt + LVL_ONE;
        2'b01:   last_cnt <= last_cnt - LVL_ONE;
        default: last_cnt <= last_cnt;
      endcase
      if (issue) half_sel <= ~half_sel;
    end
  end

  assign fifo_level = level;

  // ---------------- output register ----------------
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      out_valid  <= 1'b0;
      out_sample <= 14'd0;
      out_last   <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_sample <= conv;
      out_last   <= rd_word[WORD_W-1] && half_sel;
`ifdef PACER_UNDERRUN_FILL_EN
    end else if (starved) begin
      out_valid  <= 1'b1;
      out_sample <= MIDSCALE;
      out_last   <= 1'b0;
`endif
    end else if (out_hs) begin
      out_valid  <= 1'b0;
    end
  end

`ifndef PACER_UNDERRUN_FILL_EN
  logic unused_midscale;
  assign unused_midscale = ^MIDSCALE;
`endif

  assign m00_axis_tvalid = out_valid;
  assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-14){1'b0}}, out_sample};
  assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){out_valid}};
  assign m00_axis_tlast  = out_last;

endmodule

// File: tb/tb_axis_dac_sample_pacer.sv
// Directed bench for axis_dac_sample_pacer: conversion table streamed through the pacer,
// plus hand-written sequences for stall, underrun, full FIFO, stop/flush and reset.
module tb_axis_dac_sample_pacer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [15:0]   rate_div;
  logic [AW:0]   prime_level;
  logic          s_ready;
  logic [31:0]   s_data;
  logic [3:0]    s_strb;
  logic          s_last;
  logic          s_valid;
  logic          m_valid;
  logic [31:0]   m_data;
  logic [3:0]    m_strb;
  logic          m_last;
  logic          m_ready;
  logic [15:0]   underrun;
  logic [AW:0]   level;
  logic [1:0]    state;

  always #5 clk = ~clk;

  axis_dac_sample_pacer #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .FIFO_DEPTH(16),
    .FIFO_AW(AW)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .enable          (enable),
    .rate_div        (rate_div),
    .prime_level     (prime_level),
    .s00_axis_tready (s_ready),
    .s00_axis_tdata  (s_data),
    .s00_axis_tstrb  (s_strb),
    .s00_axis_tlast  (s_last),
    .s00_axis_tvalid (s_valid),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tdata  (m_data),
    .m00_axis_tstrb  (m_strb),
    .m00_axis_tlast  (m_last),
    .m00_axis_tready (m_ready),
    .underrun_count  (underrun),
    .fifo_level      (level),
    .state           (state)
  );

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [13:0] exp_lo;
    logic [13:0] exp_hi;
  } vec_t;

  vec_t vecs[7];

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [32:0] got_q[$];
  int unsigned got_cyc[$];
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, records transfers that complete on the next edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back({m_last, m_data});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = 4'hF;
    s_last = 1'b0; m_ready = 1'b1; rate_div = 16'd1; prime_level = 5'd1;
    step(2);
    rst_n = 1'b1;
    step(1);
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] data, input logic last);
    logic hs;
    int   k;
    hs = 1'b0;
    s_valid = 1'b1; s_data = data; s_last = last;
    for (k = 0; k < 64; k++) begin
      hs = s_ready;
      step(1);
      if (hs) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("push_handshake", hs, 1);
  endtask

  task automatic wait_samples(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(name, got_q.size() >= n, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (m_valid !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    check(name, m_valid, 1);
  endtask

  task automatic compare_samples(input string name);
    logic [32:0] e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) a = got_q.pop_front();
      else                  a = 'x;
      check(name, a, e);
    end
  endtask

  task automatic start_run(input logic [15:0] rd, input logic [AW:0] pl);
    rate_div = rd; prime_level = pl; enable = 1'b1;
    step(1);
  endtask

  initial begin
    logic [31:0] held;
    logic        stable;

    vecs[0] = '{32'h7FFF_0000, 1'b0, 14'h2000, 14'h3FFF};
    vecs[1] = '{32'hFFFC_8000, 1'b0, 14'h0000, 14'h1FFF};
    vecs[2] = '{32'h0004_FFFF, 1'b0, 14'h1FFF, 14'h2001};
    vecs[3] = '{32'h8003_7FFC, 1'b0, 14'h3FFF, 14'h0000};
    vecs[4] = '{32'h1234_5678, 1'b0, 14'h359E, 14'h248D};
    vecs[5] = '{32'hC000_4000, 1'b0, 14'h3000, 14'h1000};
    vecs[6] = '{32'h0001_FFFE, 1'b1, 14'h1FFF, 14'h2000};

    // Basic burst: rate 4, prime 2, tlast on the second word.
    do_reset();
    check("idle_after_reset", state, 0);
    start_run(16'd4, 5'd2);
    check("t2_prime_state", state, 1);
    push_word(32'h7FFF_0000, 1'b0);
    push_word(32'h8000_0004, 1'b1);
    exp_q.push_back(33'h0_0000_2000);
    exp_q.push_back(33'h0_0000_3FFF);
    exp_q.push_back(33'h0_0000_2001);
    exp_q.push_back(33'h1_0000_0000);
    wait_samples("t2_sample_count", 4, 80);
    for (int i = 1; i < 4; i++)
      if (i < got_cyc.size()) check("t2_spacing", got_cyc[i] - got_cyc[i-1], 4);
    compare_samples("t2_sample");
    step(2);
    check("t2_state_prime", state, 1);
    check("t2_underrun", underrun, 0);

    // Same burst with the second sample stalled for 10 clocks.
    do_reset();
    start_run(16'd4, 5'd2);
    push_word(32'h7FFF_0000, 1'b0);
    push_word(32'h8000_0004, 1'b1);
    exp_q.push_back(33'h0_0000_2000);
    exp_q.push_back(33'h0_0000_3FFF);
    exp_q.push_back(33'h0_0000_2001);
    exp_q.push_back(33'h1_0000_0000);
    wait_samples("t3_first", 1, 40);
    m_ready = 1'b0;
    wait_valid("t3_second_valid", 20);
    held = m_data;
    check("t3_tstrb_valid", m_strb, 4'hF);
    stable = 1'b1;
    repeat (10) begin
      step(1);
      if (m_data !== held || m_valid !== 1'b1) stable = 1'b0;
    end
    check("t3_hold_stable", stable, 1);
    check("t3_held_data", held, 32'h0000_3FFF);
    m_ready = 1'b1;
    wait_samples("t3_sample_count", 4, 60);
    if (got_cyc.size() >= 3) check("t3_pending_served", got_cyc[2] - got_cyc[1], 1);
    compare_samples("t3_sample");
    step(2);
    check("t3_underrun", underrun, 0);
    check("t3_state_prime", state, 1);
    check("t3_tstrb_idle", m_strb, 4'h0);

    // Conversion table, rate_div=0 (treated as 1), RUN triggered by the tlast word;
    // three passes without reset so the FIFO pointers wrap.
    do_reset();
    start_run(16'd0, 5'd8);
    for (int pass = 0; pass < 3; pass++) begin
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 7; i++) begin
        push_word(vecs[i].word, vecs[i].last);
        exp_q.push_back({1'b0, 18'b0, vecs[i].exp_lo});
        exp_q.push_back({vecs[i].last, 18'b0, vecs[i].exp_hi});
      end
      wait_samples("tbl_sample_count", 14, 120);
      if (got_cyc.size() >= 14) check("tbl_rate1_span", got_cyc[13] - got_cyc[0], 13);
      compare_samples("tbl_sample");
      step(2);
      check("tbl_state_prime", state, 1);
      check("tbl_fifo_empty", level, 0);
    end
    check("tbl_underrun", underrun, 0);

    // Starvation: one word, rate 2; three starved ticks after it drains.
    do_reset();
    start_run(16'd2, 5'd1);
    push_word(32'h1234_5678, 1'b0);
    exp_q.push_back(33'h0_0000_359E);
    exp_q.push_back(33'h0_0000_248D);
    wait_samples("t4_sample_count", 2, 40);
    compare_samples("t4_sample");
    step(6);
    check("t4_underrun", underrun, 3);
    check("t4_state_run", state, 2);
`ifdef PACER_UNDERRUN_FILL_EN
    check("t4_fill_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(33'h0_0000_2000);
    compare_samples("t4_fill_sample");
`else
    check("t4_no_emit", got_q.size(), 0);
    check("t4_valid_low", m_valid, 0);
`endif

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_tvalid", m_valid, 0);
    check("rst_tdata", m_data, 0);
    check("rst_tstrb", m_strb, 0);
    check("rst_tlast", m_last, 0);
    check("rst_s_tready", s_ready, 0);
    check("rst_level", level, 0);
    check("rst_underrun", underrun, 0);

    // Full FIFO with prime_level above depth (clamped to 16).
    do_reset();
    start_run(16'd100, 5'd20);
    for (int i = 0; i < 16; i++)
      push_word({16'(i * 4 + 2), 16'(i * 4)}, 1'b0);
    check("t5_level_full", level, 16);
    check("t5_tready_full", s_ready, 0);
    check("t5_still_prime", state, 1);
    step(1);
    check("t5_run_entered", state, 2);
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    step(3);
    s_valid = 1'b0;
    check("t5_no_overflow", level, 16);
    check("t5_tready_run_full", s_ready, 0);
    check("t5_first_sample", m_data, 32'h0000_2000);

    // Stop while the output is stalled, then restart to confirm a clean flush.
    do_reset();
    m_ready = 1'b0;
    start_run(16'd2, 5'd1);
    push_word(32'h0000_7FFC, 1'b0);
    wait_valid("t6_valid", 20);
    enable = 1'b0;
    step(1);
    check("t6_state_stop", state, 3);
    check("t6_s_tready", s_ready, 0);
    step(3);
    check("t6_still_stop", state, 3);
    check("t6_valid_held", m_valid, 1);
    check("t6_data_held", m_data, 32'h0000_3FFF);
    check("t6_level_held", level, 1);
    m_ready = 1'b1;
    step(1);
    check("t6_valid_done", m_valid, 0);
    check("t6_state_idle", state, 0);
    check("t6_level_flushed", level, 0);
    got_q.delete(); got_cyc.delete();
    start_run(16'd2, 5'd1);
    push_word(32'hABCD_0004, 1'b0);
    exp_q.push_back(33'h0_0000_2001);
    wait_samples("t6_restart_count", 1, 20);
    compare_samples("t6_restart_low_first");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
